// File: rtl/led_breather_if.sv
// led_breather_if: LED-drive interface bundling the enable level, the PWM
// outputs and the busy flag. The controller (master) drives enable and
// observes led/busy; the breather (slave) drives led/busy.
interface led_breather_if #(
  parameter int CHANNELS = 8
);
  logic                enable;
  logic [CHANNELS-1:0] led;
  logic                busy;

  modport master (output enable, input led, input busy);
  modport slave  (input enable, output led, output busy);
endinterface

// File: rtl/led_breather.sv
// led_breather: per-channel PWM "breathing" LED driver. A triangle-wave
// brightness is derived from a shared phase counter P, with each channel
// offset by PHASE_STEP. A ceiling C ramps up on enable (soft start) and
// ramps back down on disable (soft drain). Duties are latched once per
// PWM period so each period uses one stable duty.
// Optional feature macro: LED_BREATHER_GAMMA_EN (square-law gamma on the
// latched duty).
module led_breather #(
  parameter int CHANNELS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int STEP_DIV   = 50000,
  parameter int PHASE_STEP = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  led_breather_if.slave    bus
);

  localparam int PW    = PWM_BITS + 1;
  localparam int DIV_W = $clog2(STEP_DIV);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t               state_q, state_d;
  logic [DIV_W-1:0]     presc_q, presc_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [PW-1:0]        p_q, p_d;
  logic [PWM_BITS-1:0]  c_q, c_d;
  logic [PWM_BITS-1:0]  duty_q [CHANNELS];
  logic [PWM_BITS-1:0]  duty_d [CHANNELS];
  logic [CHANNELS-1:0]  led_q, led_d;
  logic                 busy_q, busy_d;

  logic                 step;
  logic                 latch;
  logic [PW-1:0]        phase_x [CHANNELS];
  logic [PWM_BITS-1:0]  raw     [CHANNELS];
  logic [PWM_BITS-1:0]  eff     [CHANNELS];
  logic [PWM_BITS-1:0]  shaped  [CHANNELS];
`ifdef LED_BREATHER_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq     [CHANNELS];
`endif

  assign step  = (presc_q == DIV_LAST);
  assign latch = (pwm_cnt_q == DUTY_MAX);

  // Free-running step prescaler and PWM counter, both unaffected by state.
  always_comb begin
    presc_d   = step ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
  end

  // Per-channel triangle fold of the phased counter, clipped by the ceiling.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      phase_x[i] = p_q + PW'(i * PHASE_STEP);
      raw[i]     = phase_x[i][PW-1] ? ~phase_x[i][PWM_BITS-1:0]
                                    :  phase_x[i][PWM_BITS-1:0];
      eff[i]     = (raw[i] < c_q) ? raw[i] : c_q;
`ifdef LED_BREATHER_GAMMA_EN
      sq[i]      = (2*PWM_BITS)'(eff[i]) * (2*PWM_BITS)'(eff[i]);
      shaped[i]  = PWM_BITS'(sq[i] >> PWM_BITS);
`else
      shaped[i]  = eff[i];
`endif
    end
  end

  // Duty latch at the end of each PWM period, and the registered compare.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      duty_d[i] = latch ? shaped[i] : duty_q[i];
      led_d[i]  = (pwm_cnt_q < duty_q[i]);
    end
  end

  // Breathing FSM: phase advance and ceiling ramp/drain on each step.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    case (state_q)
      ST_OFF: begin
        p_d = '0;
        c_d = '0;
        if (bus.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (step) begin
          p_d = p_q + 1'b1;
          if (c_q != DUTY_MAX) c_d = c_q + 1'b1;
        end
        if (!bus.enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (c_q == '0) begin
          if (bus.enable) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_OFF;
            p_d     = '0;
          end
        end else begin
          if (step) begin
            p_d = p_q + 1'b1;
            c_d = c_q - 1'b1;
          end
          if (bus.enable) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_OFF;
        p_d     = '0;
        c_d     = '0;
      end
    endcase
    busy_d = (state_d != ST_OFF);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      p_q       <= '0;
      c_q       <= '0;
      led_q     <= '0;
      busy_q    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      p_q       <= p_d;
      c_q       <= c_d;
      led_q     <= led_d;
      busy_q    <= busy_d;
      for (int i = 0; i < CHANNELS; i++) duty_q[i] <= duty_d[i];
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_led_breather.sv
// tb_led_breather: directed bench for led_breather with CHANNELS=2,
// PWM_BITS=4, STEP_DIV=4, PHASE_STEP=8. Edge n counts rising edges after
// reset release; steps occur at n = 4k and duty latches at n = 16m.
module tb_led_breather;

  localparam int CH = 2;
  localparam int PB = 4;
  localparam int SD = 4;
  localparam int PS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  led_breather_if #(.CHANNELS(CH)) bus_if ();

  led_breather #(
    .CHANNELS  (CH),
    .PWM_BITS  (PB),
    .STEP_DIV  (SD),
    .PHASE_STEP(PS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    int   exp_p;
    int   exp_c;
    int   exp_d0;
    int   exp_d1;
  } vec_t;

  vec_t tbl [8];
  int   checks = 0;
  int   errors = 0;
  int   n      = 0;
  int   cnt0, cnt1;

  function automatic int gam(input int d);
`ifdef LED_BREATHER_GAMMA_EN
    return (d * d) >> PB;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at n=%0d: got %0d, want %0d", name, n, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input int cycles);
    bus_if.enable = en;
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic countPeriod(output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      c0 += int'(bus_if.led[0]);
      c1 += int'(bus_if.led[1]);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1,  4,  4,  3,  3};
    tbl[1] = '{1'b1,  8,  8,  7,  7};
    tbl[2] = '{1'b1, 12, 12, 11, 11};
    tbl[3] = '{1'b1, 16, 15, 15,  8};
    tbl[4] = '{1'b1, 20, 15, 12,  4};
    tbl[5] = '{1'b1, 24, 15,  8,  0};
    tbl[6] = '{1'b1, 28, 15,  4,  3};
    tbl[7] = '{1'b1,  0, 15,  0,  7};

    // Reset held with enable high
    rst_n = 1'b0;
    bus_if.enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_led",  int'(bus_if.led), 0);
    checkOutput("reset_busy", int'(bus_if.busy), 0);
    checkOutput("reset_c",    int'(dut.c_q), 0);

    // First edge out of reset leaves OFF
    rst_n = 1'b1;
    n = 0;
    tick();
    checkOutput("start_busy", int'(bus_if.busy), 1);
    checkOutput("start_c",    int'(dut.c_q), 0);
    applyStimulus(1'b1, 15);

    // Soft start and breathing: one record per PWM period
    for (int m = 0; m < 8; m++) begin
      bus_if.enable = tbl[m].en;
      checkOutput("tbl_p",  int'(dut.p_q), tbl[m].exp_p);
      checkOutput("tbl_c",  int'(dut.c_q), tbl[m].exp_c);
      checkOutput("tbl_d0", int'(dut.duty_q[0]), gam(tbl[m].exp_d0));
      checkOutput("tbl_d1", int'(dut.duty_q[1]), gam(tbl[m].exp_d1));
      countPeriod(cnt0, cnt1);
      checkOutput("tbl_on0", cnt0, gam(tbl[m].exp_d0));
      checkOutput("tbl_on1", cnt1, gam(tbl[m].exp_d1));
    end
    checkOutput("run_busy", int'(bus_if.busy), 1);

    // Drain from full ceiling down to C=7 at n=176
    applyStimulus(1'b0, 32);
    checkOutput("drain_c",    int'(dut.c_q), 7);
    checkOutput("drain_busy", int'(bus_if.busy), 1);
    checkOutput("drain_d0",   int'(dut.duty_q[0]), gam(8));
    checkOutput("drain_d1",   int'(dut.duty_q[1]), gam(8));

    // Re-enable at C=6 inside a PWM period; period output must stay clean
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 16; k++) begin
      if (n == 180) begin
        checkOutput("reen_c_before", int'(dut.c_q), 6);
        bus_if.enable = 1'b1;
      end
      tick();
      cnt0 += int'(bus_if.led[0]);
      cnt1 += int'(bus_if.led[1]);
      if (n == 181) checkOutput("reen_c_hold", int'(dut.c_q), 6);
      if (n == 184) checkOutput("reen_c_next", int'(dut.c_q), 7);
    end
    checkOutput("reen_on0", cnt0, gam(8));
    checkOutput("reen_on1", cnt1, gam(8));
    checkOutput("reen_c",   int'(dut.c_q), 9);
    checkOutput("reen_p",   int'(dut.p_q), 16);

    // Full drain to OFF
    applyStimulus(1'b0, 36);
    checkOutput("fin_c0",    int'(dut.c_q), 0);
    checkOutput("fin_busy1", int'(bus_if.busy), 1);
    tick();
    checkOutput("off_busy", int'(bus_if.busy), 0);
    checkOutput("off_p",    int'(dut.p_q), 0);
    checkOutput("off_c",    int'(dut.c_q), 0);
    applyStimulus(1'b0, 11);
    countPeriod(cnt0, cnt1);
    checkOutput("dark_on0",  cnt0, 0);
    checkOutput("dark_on1",  cnt1, 0);
    checkOutput("dark_busy", int'(bus_if.busy), 0);
    checkOutput("dark_p",    int'(dut.p_q), 0);

    // Reset mid-operation takes effect on that edge
    applyStimulus(1'b1, 20);
    checkOutput("mid_busy", int'(bus_if.busy), 1);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_busy", int'(bus_if.busy), 0);
    checkOutput("mid_rst_led",  int'(bus_if.led), 0);
    checkOutput("mid_rst_c",    int'(dut.c_q), 0);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_breather.md
Name: led_breather

Overview:
- Downstream LED-drive stage for the Mojo board.
- Replaces the raw square-wave blinkers with per-channel PWM "breathing": triangle-wave brightness, staggered phase per LED.
- Soft start when enabled; soft drain to dark when disabled.
- Runs off the 50 MHz board clock; outputs go straight to led[7:0] at top level.

Parameters:
- CHANNELS, 8, number of LED outputs.
- PWM_BITS, 8, PWM resolution; duty range 0..2^PWM_BITS-1.
- STEP_DIV, 50000, clk cycles per brightness step (1 ms at 50 MHz); must be >= 2.
- PHASE_STEP, 64, phase offset added per channel index, in units of phase counts (phase counter width PWM_BITS+1).

Ports:
- clk  input  1  board clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- enable  input  1  level; 1 = breathe, 0 = fade out and stop.
- led  output  CHANNELS  PWM outputs, registered, active high.
- busy  output  1  high in any state other than OFF.

Behaviour:
- Reset (rst_n=0 at edge): state=OFF, prescaler=0, pwm_cnt=0, phase P=0, ceiling C=0, all latched duties=0, led=0, busy=0. Reset mid-operation is immediate on that edge; no drain.
- Prescaler: counts 0..STEP_DIV-1, free-running in all states. step pulse is one cycle when prescaler==STEP_DIV-1.
- pwm_cnt: PWM_BITS wide, increments every clk, wraps at 2^PWM_BITS-1 -> 0.
- Per-channel raw duty:
  - x_i = (P + i*PHASE_STEP) mod 2^(PWM_BITS+1).
  - raw_i = x_i[PWM_BITS] ? ~x_i[PWM_BITS-1:0] : x_i[PWM_BITS-1:0] (triangle fold).
- Effective duty: eff_i = min(raw_i, C).
- Duty latch: eff_i is copied into duty_q_i only on the cycle pwm_cnt==2^PWM_BITS-1, so each PWM period uses one stable duty (glitch-free).
- Output: led[i] <= (pwm_cnt < duty_q_i), registered.
  - Duty 0 gives a constant 0.
  - Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS; no 100% on-time, by design.
- FSM:
  - OFF:
    - C=0, P held at 0.
    - enable=1 -> RUN.
  - RUN:
    - On step: P increments mod 2^(PWM_BITS+1); C increments, saturating at 2^PWM_BITS-1 (soft start).
    - enable=0 -> DRAIN.
  - DRAIN:
    - On step: P keeps advancing; C decrements by 1.
    - When C==0 at a step (or on entry with C==0): go to OFF and clear P.
    - enable=1 -> RUN; C resumes incrementing from its current value (no jump).
- Simultaneous events:
  - enable toggles on a step cycle: the state transition and the step update for the current state both happen on that edge, using the pre-edge state.
  - A step coinciding with a duty latch: the latch captures the pre-edge eff_i.
- busy = (state != OFF), registered with the state.

Optional Feature:
- Macro LED_BREATHER_GAMMA_EN.
- Defined: eff_i is replaced by (eff_i*eff_i) >> PWM_BITS before latching (square-law perceptual gamma). The multiplier is 2*PWM_BITS wide, and the result is truncated to PWM_BITS.
- Undefined: linear eff_i is latched; no multiplier is synthesised.

Test Plan:
All scenarios use CHANNELS=2, PWM_BITS=4, STEP_DIV=4, PHASE_STEP=8, gamma off, unless noted.
- Reset: hold rst_n=0 for 3 clks with enable=1 -> led=00, busy=0; first edge with rst_n=1 and enable=1 -> busy=1 next cycle.
- Soft start: enable=1 from OFF -> C reaches 15 after 15 steps (60 clks). Channel 0 duty_q follows min(P,C); ch1 (x=P+8) reaches raw 15 at P=7.
- PWM shape: force steady RUN, duty_q_0=5 -> led[0] high exactly 5 of every 16 clks; duty changes only at the pwm_cnt 15->0 boundary.
- Drain: enable=0 with C=15 -> C decrements per step; OFF after 15 steps; led=00 and busy=0 thereafter; P reads 0.
- Re-enable mid-drain at C=6 -> state RUN; next step C=7; no led glitch within the current PWM period.
- LED_BREATHER_GAMMA_EN defined, eff=8 -> duty_q=4; eff=15 -> 14; eff=1 -> 0.
